// File: rtl/edge_event_scheduler_if.sv
// Event handshake bundle between the edge scheduler and its consumer.
// Carries the offered line index with valid/ready qualification.
// The producer holds valid and id stable until ready is seen.
interface edge_event_scheduler_if #(
  parameter int NUM_LINES = 8
);
  localparam int IDX_W = $clog2(NUM_LINES);

  logic             evt_valid;
  logic             evt_ready;
  logic [IDX_W-1:0] evt_id;

  modport master (
    output evt_valid,
    output evt_id,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    output evt_ready
  );
endinterface

// File: rtl/edge_event_scheduler.sv
// Per-line edge detector with pending/overrun tracking and a round-robin event server.
// Latency: edge sampled at T -> pending after T -> evt_valid after T+1; one event/cycle back-to-back.
// Backpressure: offered event held while ready is low; further edges on pending lines flag overrun.
module edge_event_scheduler #(
  parameter int NUM_LINES = 8
) (
  input  logic                   clk_i,
  input  logic                   arst_ni,
  input  logic [NUM_LINES-1:0]   lines_i,
  input  logic [2*NUM_LINES-1:0] mode_i,
  edge_event_scheduler_if.master evt_o,
  output logic [NUM_LINES-1:0]   pending_o,
  output logic [NUM_LINES-1:0]   overrun_o,
  input  logic [NUM_LINES-1:0]   overrun_clr_i
);
  localparam int IDX_W = $clog2(NUM_LINES);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_LINES-1:0] prev_q;
  logic [NUM_LINES-1:0] pending_q, pending_d;
  logic [NUM_LINES-1:0] overrun_q, overrun_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     evt_id_q, evt_id_d;
  logic                 evt_valid_q, evt_valid_d;

  logic [NUM_LINES-1:0] line_en;
  logic [NUM_LINES-1:0] edge_det;
  logic [NUM_LINES-1:0] cand;
  logic [NUM_LINES-1:0] take_vec;
  logic [NUM_LINES-1:0] overrun_set;
  logic                 found;
  logic [IDX_W-1:0]     win_idx;
  logic                 take;

  // Per-line edge qualification against the selected mode; mode 00 disables the line.
  always_comb begin
    line_en  = '0;
    edge_det = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      line_en[i]  = (mode_i[2*i +: 2] != 2'b00);
      edge_det[i] = ((mode_i[2*i +: 2] == 2'b01) & ~prev_q[i] &  lines_i[i]) |
                    ((mode_i[2*i +: 2] == 2'b10) &  prev_q[i] & ~lines_i[i]) |
                    ((mode_i[2*i +: 2] == 2'b11) & (prev_q[i] ^  lines_i[i]));
    end
  end

  // Disabled lines are never served even if their pending bit has not yet been flushed.
  assign cand = pending_q & line_en;

  // Round-robin pick: first candidate scanning upward from rr_ptr+1 with wrap-around.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= NUM_LINES; k++) begin
      if (!found && cand[(int'(rr_ptr_q) + k) % NUM_LINES]) begin
        found   = 1'b1;
        win_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_LINES);
      end
    end
  end

  // Serving FSM: load a winner from IDLE, or chain the next one on a handshake in OFFER.
  always_comb begin
    state_d     = state_q;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    rr_ptr_d    = rr_ptr_q;
    take        = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          take        = 1'b1;
          evt_valid_d = 1'b1;
          evt_id_d    = win_idx;
          rr_ptr_d    = win_idx;
          state_d     = OFFER;
        end
      end
      OFFER: begin
        if (evt_o.evt_ready) begin
          if (found) begin
            take     = 1'b1;
            evt_id_d = win_idx;
            rr_ptr_d = win_idx;
          end else begin
            evt_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: begin
        evt_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // Pending/overrun next state; an edge on the line being consumed re-arms it without overrun.
  always_comb begin
    take_vec = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      take_vec[i] = take && (win_idx == IDX_W'(i));
    end
    pending_d   = ((pending_q & ~take_vec) | edge_det) & line_en;
    overrun_set = edge_det & pending_q & ~take_vec;
    overrun_d   = (overrun_q & ~overrun_clr_i) | overrun_set;
  end

  // State registers; reset leaves line 0 with first priority.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      pending_q   <= '0;
      overrun_q   <= '0;
      rr_ptr_q    <= IDX_W'(NUM_LINES - 1);
      evt_id_q    <= '0;
      evt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= lines_i;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      rr_ptr_q    <= rr_ptr_d;
      evt_id_q    <= evt_id_d;
      evt_valid_q <= evt_valid_d;
    end
  end

  assign evt_o.evt_valid = evt_valid_q;
  assign evt_o.evt_id    = evt_id_q;
  assign pending_o       = pending_q;
  assign overrun_o       = overrun_q;

endmodule
